armleocpu_mem_responder: RTL and testbench

Bus responder (target side) for the CPU's d/i memory transaction interface (transaction/cmd/address/burstcount/wdata/wbyte_enable initiator, done/response/rdata return).
- Backs the bus with a word-addressed on-chip RAM and serves single and burst reads/writes with a configurable fixed access latency.
- Used as boot/scratch memory and as the bench memory model for the icache/dcache ports.

---
 rtl/armleocpu_mem_responder.sv | 151 +++++++++++++++
 tb/tb_armleocpu_mem_responder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/armleocpu_mem_responder.sv
// Target-side responder for the CPU memory transaction bus, backed by a word-addressed RAM.
// Serves single and burst reads/writes after a fixed access latency; bad commands or ranges get one error beat.
module armleocpu_mem_responder #(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [33:0] BASE_ADDR  = 34'h0,
  parameter int          LATENCY    = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        transaction_i,
  input  logic [2:0]  cmd_i,
  input  logic [33:0] address_i,
  input  logic [3:0]  burstcount_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wbyte_enable_i,
  output logic        transaction_done_o,
  output logic [2:0]  transaction_response_o,
  output logic [31:0] rdata_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_BEAT,
    S_ERR,
    S_RELEASE
  } state_t;

  localparam int          DEPTH            = 1 << DEPTH_LOG2;
  localparam logic [2:0]  CMD_READ         = 3'd1;
  localparam logic [2:0]  CMD_WRITE        = 3'd2;
  localparam logic [2:0]  RESP_OKAY        = 3'd0;
  localparam logic [2:0]  RESP_INVALID_CMD = 3'd1;
  localparam logic [2:0]  RESP_ADDR_ERROR  = 3'd2;
  localparam logic [3:0]  WAIT_INIT        = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
  localparam logic [DEPTH_LOG2-1:0] IDX_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  state_t                 state_q, state_d;
  logic                   write_q, write_d;
  logic [DEPTH_LOG2-1:0]  idx_q, idx_d;
  logic [3:0]             beatCnt_q, beatCnt_d;
  logic [3:0]             waitCnt_q, waitCnt_d;
  logic [2:0]             resp_q, resp_d;
  logic [31:0]            rdata_q;
  logic                   memWe;
  logic [31:0]            mem [DEPTH];

  logic [31:0] wordOff;
  logic [32:0] lastWord;
  logic        addrErr;

  // The whole burst must fit below the top of RAM; nothing wraps around.
  assign wordOff  = address_i[33:2] - BASE_ADDR[33:2];
  assign lastWord = {1'b0, wordOff} + 33'(burstcount_i);
  assign addrErr  = (address_i[1:0] != 2'b00) || (address_i < BASE_ADDR) ||
                    (lastWord >= 33'(DEPTH));

  always_comb begin
    state_d            = state_q;
    write_d            = write_q;
    idx_d              = idx_q;
    beatCnt_d          = beatCnt_q;
    waitCnt_d          = waitCnt_q;
    resp_d             = resp_q;
    transaction_done_o = 1'b0;
    memWe              = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (transaction_i) begin
          write_d   = (cmd_i == CMD_WRITE);
          idx_d     = wordOff[DEPTH_LOG2-1:0];
          beatCnt_d = burstcount_i;
          waitCnt_d = WAIT_INIT;
          if (cmd_i != CMD_READ && cmd_i != CMD_WRITE) begin
            resp_d  = RESP_INVALID_CMD;
            state_d = S_ERR;
          end else if (addrErr) begin
            resp_d  = RESP_ADDR_ERROR;
            state_d = S_ERR;
          end else begin
            resp_d  = RESP_OKAY;
            state_d = (LATENCY > 0) ? S_WAIT : S_BEAT;
          end
        end
      end
      S_WAIT: begin
        if (waitCnt_q == 4'd0) begin
          state_d = S_BEAT;
        end else begin
          waitCnt_d = waitCnt_q - 4'd1;
        end
      end
      S_BEAT: begin
        // A dropped transaction still advances the burst, but neither acks nor writes.
        transaction_done_o = transaction_i;
        memWe              = write_q && transaction_i;
        if (beatCnt_q == 4'd0) begin
          state_d = S_RELEASE;
        end else begin
          beatCnt_d = beatCnt_q - 4'd1;
          idx_d     = idx_q + IDX_ONE;
        end
      end
      S_ERR: begin
        transaction_done_o = transaction_i;
        state_d            = S_RELEASE;
      end
      S_RELEASE: begin
        if (!transaction_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      write_q   <= 1'b0;
      idx_q     <= '0;
      beatCnt_q <= 4'd0;
      waitCnt_q <= 4'd0;
      resp_q    <= RESP_OKAY;
      rdata_q   <= 32'd0;
    end else begin
      state_q   <= state_d;
      write_q   <= write_d;
      idx_q     <= idx_d;
      beatCnt_q <= beatCnt_d;
      waitCnt_q <= waitCnt_d;
      resp_q    <= resp_d;
      // Read the word the next cycle will present, so rdata lines up with done.
      rdata_q   <= mem[idx_d];
    end
  end

  always_ff @(posedge clk_i) begin
    if (memWe) begin
      for (int lane = 0; lane < 4; lane++) begin
        if (wbyte_enable_i[lane]) begin
          mem[idx_q][8*lane +: 8] <= wdata_i[8*lane +: 8];
        end
      end
    end
  end

  assign transaction_response_o = resp_q;
  assign rdata_o                = rdata_q;

endmodule

// File: tb/tb_armleocpu_mem_responder.sv
// Self-checking bench for armleocpu_mem_responder: directed vector table, reset-mid-burst
// sequence and randomized transactions compared against a plain array memory model.
module tb_armleocpu_mem_responder;

  localparam int          DEPTH_LOG2 = 10;
  localparam int          DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [33:0] BASE_ADDR  = 34'h0;
  localparam int          LATENCY    = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        transaction;
  logic [2:0]  cmd;
  logic [33:0] address;
  logic [3:0]  burstcount;
  logic [31:0] wdata;
  logic [3:0]  wbyteEnable;
  logic        done;
  logic [2:0]  response;
  logic [31:0] rdata;

  int checks   = 0;
  int failures = 0;

  logic [31:0] model [DEPTH];

  typedef struct {
    logic [2:0]        cmd;
    logic [33:0]       addr;
    logic [3:0]        bc;
    logic [15:0][31:0] wd;
    logic [3:0]        be;
    logic [2:0]        expResp;
    logic [15:0][31:0] expData;
  } vec_t;

  armleocpu_mem_responder #(
    .DEPTH_LOG2(DEPTH_LOG2),
    .BASE_ADDR (BASE_ADDR),
    .LATENCY   (LATENCY)
  ) dut (
    .clk_i                 (clk),
    .rst_i                 (rst),
    .transaction_i         (transaction),
    .cmd_i                 (cmd),
    .address_i             (address),
    .burstcount_i          (burstcount),
    .wdata_i               (wdata),
    .wbyte_enable_i        (wbyteEnable),
    .transaction_done_o    (done),
    .transaction_response_o(response),
    .rdata_o               (rdata)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Response dictated by the command and the byte range of the whole burst.
  function automatic logic [2:0] expectedResp(input logic [2:0] c, input logic [33:0] a, input int bc);
    longint firstWord;
    if (c != 3'd1 && c != 3'd2) return 3'd1;
    if (a % 4 != 0) return 3'd2;
    if (a < BASE_ADDR) return 3'd2;
    firstWord = (longint'(a) - longint'(BASE_ADDR)) / 4;
    if (firstWord + bc >= DEPTH) return 3'd2;
    return 3'd0;
  endfunction

  function automatic int wordIndex(input logic [33:0] a);
    return int'((longint'(a) - longint'(BASE_ADDR)) / 4);
  endfunction

  function automatic vec_t mk(input logic [2:0] c, input logic [33:0] a, input logic [3:0] bc,
                              input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                              input logic [31:0] w3, input logic [3:0] be, input logic [2:0] resp,
                              input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2,
                              input logic [31:0] e3);
    vec_t v;
    v.cmd = c; v.addr = a; v.bc = bc; v.be = be; v.expResp = resp;
    v.wd = '0; v.expData = '0;
    v.wd[0] = w0; v.wd[1] = w1; v.wd[2] = w2; v.wd[3] = w3;
    v.expData[0] = e0; v.expData[1] = e1; v.expData[2] = e2; v.expData[3] = e3;
    return v;
  endfunction

  // Runs one full transaction from request to the idle gap, checking every beat.
  task automatic applyStimulus(input string name, input logic [2:0] tCmd, input logic [33:0] tAddr,
                               input logic [3:0] tBc, input logic [15:0][31:0] tWd,
                               input logic [15:0][3:0] tBe, input logic [2:0] tResp,
                               input logic [15:0][31:0] tExp, input int hold);
    int expBeats, beats, cycles, firstDone, extra, base;
    expBeats  = (tResp == 3'd0) ? int'(tBc) + 1 : 1;
    beats     = 0;
    cycles    = 0;
    firstDone = 0;
    transaction = 1'b1; cmd = tCmd; address = tAddr; burstcount = tBc;
    wdata = tWd[0]; wbyteEnable = tBe[0];
    while (beats < expBeats && cycles < 100) begin
      @(negedge clk);
      cycles++;
      if (done) begin
        if (beats == 0) firstDone = cycles;
        checkOutput($sformatf("%s resp[%0d]", name, beats), 32'(response), 32'(tResp));
        if (tCmd == 3'd1 && tResp == 3'd0)
          checkOutput($sformatf("%s rdata[%0d]", name, beats), rdata, tExp[beats]);
        beats++;
      end
      @(posedge clk); #1;
      if (beats < 16) begin
        wdata = tWd[beats]; wbyteEnable = tBe[beats];
      end
    end
    checkOutput($sformatf("%s beats", name), 32'(beats), 32'(expBeats));
    checkOutput($sformatf("%s latency", name), 32'(firstDone),
                32'((tResp == 3'd0) ? LATENCY + 2 : 2));
    if (tCmd == 3'd2 && tResp == 3'd0) begin
      base = wordIndex(tAddr);
      for (int k = 0; k <= int'(tBc); k++)
        for (int l = 0; l < 4; l++)
          if (tBe[k][l]) model[base+k][8*l +: 8] = tWd[k][8*l +: 8];
    end
    if (hold > 0) begin
      extra = 0;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        if (done) extra++;
        @(posedge clk); #1;
      end
      checkOutput($sformatf("%s no done while held", name), 32'(extra), 32'd0);
    end
    transaction = 1'b0; cmd = 3'd0;
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t              vecs [14];
    logic [15:0][31:0] wd;
    logic [15:0][3:0]  be;
    logic [15:0][31:0] exp;
    logic [2:0]        rc;
    logic [33:0]       ra;
    logic [3:0]        rb;
    logic [2:0]        rr;
    int                beats, cycles, mode, base;

    rst = 1'b1; transaction = 1'b0; cmd = 3'd0; address = '0; burstcount = '0;
    wdata = '0; wbyteEnable = '0;
    #1;
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset response", 32'(response), 32'd0);
    checkOutput("reset rdata", rdata, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Preload word i with A000_0000+i through 16-beat write bursts.
    for (int b = 0; b < DEPTH / 16; b++) begin
      for (int k = 0; k < 16; k++) begin
        wd[k] = 32'hA000_0000 + 32'(b * 16 + k);
        be[k] = 4'hF;
      end
      applyStimulus($sformatf("preload%0d", b), 3'd2, 34'(b * 64), 4'd15, wd, be, 3'd0, '0, 0);
    end

    vecs[0]  = mk(3'd1, 34'h10,   4'd0, 0, 0, 0, 0, 4'h0, 3'd0, 32'hA000_0004, 0, 0, 0);
    vecs[1]  = mk(3'd2, 34'h20,   4'd3, 32'h11, 32'h22, 32'h33, 32'h44, 4'hF, 3'd0, 0, 0, 0, 0);
    vecs[2]  = mk(3'd1, 34'h20,   4'd3, 0, 0, 0, 0, 4'h0, 3'd0, 32'h11, 32'h22, 32'h33, 32'h44);
    vecs[3]  = mk(3'd2, 34'h40,   4'd0, 32'h0, 0, 0, 0, 4'hF, 3'd0, 0, 0, 0, 0);
    vecs[4]  = mk(3'd2, 34'h40,   4'd0, 32'hDEAD_BEEF, 0, 0, 0, 4'h5, 3'd0, 0, 0, 0, 0);
    vecs[5]  = mk(3'd1, 34'h40,   4'd0, 0, 0, 0, 0, 4'h0, 3'd0, 32'h00AD_00EF, 0, 0, 0);
    vecs[6]  = mk(3'd1, 34'h2,    4'd0, 0, 0, 0, 0, 4'h0, 3'd2, 0, 0, 0, 0);
    vecs[7]  = mk(3'd1, 34'hFF0,  4'd7, 0, 0, 0, 0, 4'h0, 3'd2, 0, 0, 0, 0);
    vecs[8]  = mk(3'd2, 34'hFF4,  4'd3, 1, 2, 3, 4, 4'hF, 3'd2, 0, 0, 0, 0);
    vecs[9]  = mk(3'd1, 34'hFF0,  4'd3, 0, 0, 0, 0, 4'h0, 3'd0,
                  32'hA000_03FC, 32'hA000_03FD, 32'hA000_03FE, 32'hA000_03FF);
    vecs[10] = mk(3'd5, 34'h0,    4'd0, 0, 0, 0, 0, 4'h0, 3'd1, 0, 0, 0, 0);
    vecs[11] = mk(3'd0, 34'h0,    4'd0, 0, 0, 0, 0, 4'h0, 3'd1, 0, 0, 0, 0);
    vecs[12] = mk(3'd1, 34'h1000, 4'd0, 0, 0, 0, 0, 4'h0, 3'd2, 0, 0, 0, 0);
    vecs[13] = mk(3'd1, 34'hFFC,  4'd0, 0, 0, 0, 0, 4'h0, 3'd0, 32'hA000_03FF, 0, 0, 0);

    for (int i = 0; i < 14; i++) begin
      for (int k = 0; k < 16; k++) be[k] = vecs[i].be;
      applyStimulus($sformatf("vec%0d", i), vecs[i].cmd, vecs[i].addr, vecs[i].bc,
                    vecs[i].wd, be, vecs[i].expResp, vecs[i].expData, 3);
    end

    // Reset lands while beat 3 of an 8-beat write is being acked.
    for (int k = 0; k < 16; k++) begin
      wd[k] = 32'h5500_0000 + 32'(k);
      be[k] = 4'hF;
    end
    transaction = 1'b1; cmd = 3'd2; address = 34'h200; burstcount = 4'd7;
    wdata = wd[0]; wbyteEnable = be[0];
    beats = 0; cycles = 0;
    while (beats < 3 && cycles < 100) begin
      @(negedge clk);
      cycles++;
      if (done) beats++;
      @(posedge clk); #1;
      wdata = wd[beats]; wbyteEnable = be[beats];
    end
    checkOutput("reset-burst beats before reset", 32'(beats), 32'd3);
    rst = 1'b1;
    #1;
    checkOutput("reset-burst done drops", 32'(done), 32'd0);
    checkOutput("reset-burst response", 32'(response), 32'd0);
    transaction = 1'b0; cmd = 3'd0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) model[128 + k] = wd[k];
    for (int k = 0; k < 8; k++) exp[k] = model[128 + k];
    applyStimulus("reset-burst readback", 3'd1, 34'h200, 4'd7, '0, '0, 3'd0, exp, 0);

    // Randomized traffic checked against the array model.
    for (int t = 0; t < 60; t++) begin
      mode = int'($urandom_range(0, 9));
      rc = (mode < 4) ? 3'd1 : (mode < 8) ? 3'd2 : 3'($urandom_range(0, 7));
      mode = int'($urandom_range(0, 9));
      if (mode < 7)       ra = 34'($urandom_range(0, DEPTH - 1)) * 4;
      else if (mode == 7) ra = 34'($urandom_range(0, DEPTH - 1)) * 4 + 34'($urandom_range(1, 3));
      else if (mode == 8) ra = 34'($urandom_range(DEPTH - 16, DEPTH - 1)) * 4;
      else                ra = {2'($urandom_range(0, 3)), 32'($urandom())};
      rb = 4'($urandom_range(0, 15));
      for (int k = 0; k < 16; k++) begin
        wd[k] = $urandom();
        be[k] = 4'($urandom_range(0, 15));
      end
      rr  = expectedResp(rc, ra, int'(rb));
      exp = '0;
      if (rr == 3'd0) begin
        base = wordIndex(ra);
        for (int k = 0; k <= int'(rb); k++) exp[k] = model[base + k];
      end
      applyStimulus($sformatf("rand%0d", t), rc, ra, rb, wd, be, rr, exp,
                    int'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
